ddr_req_arbiter: RTL and testbench

Schedules the shared DDR2 controller command path between two requesters: the ring memory-operation queue (reads and writes from cores) and the display controller's refresh-read port. Each cycle it decides which requester may push an address-FIFO entry. For writes, it also streams the matching 128-bit beats from the write-data queue into the controller's write buffer. It pushes a routing tag per read so that read-data return logic can steer each 128-bit line to a ring destination or to the display. It sits between the memOp/writeData queues, the display controller and the ddrController AF/WB inputs.

---
 rtl/ddr_req_arbiter_pkg.sv | 37 +++
 rtl/ddr_arb_pick.sv | 35 +++
 rtl/ddr_req_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_ddr_req_arbiter.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_req_arbiter_pkg.sv
// ddr_req_arbiter_pkg: shared state encodings, tag layout and default parameters
// for the DDR request arbiter and its grant picker.
package ddr_req_arbiter_pkg;

    typedef enum logic [0:0] {
        StIdle   = 1'b0,
        StWrData = 1'b1
    } arbState_e;

    localparam int unsigned ADDR_W = 26;
    localparam int unsigned DEST_W = 4;

    // Read-return tag: {isDisplay, dest[3:0]}
    localparam int unsigned TAG_W      = 5;
    localparam int unsigned TAG_DC_BIT = 4;

    localparam int unsigned DEF_WB_BEATS   = 2;
    localparam int unsigned DEF_READ_BIT   = 28;
    localparam int unsigned DEF_MAX_DC_RUN = 4;

    // One-hot grant bit positions
    localparam int unsigned GNT_DC = 0;
    localparam int unsigned GNT_RD = 1;
    localparam int unsigned GNT_WR = 2;

    typedef logic [2:0] grant_t;

    function automatic logic [TAG_W-1:0] makeTag(input logic isDisplay,
                                                 input logic [DEST_W-1:0] dest);
        logic [TAG_W-1:0] tag;
        tag = '0;
        tag[TAG_DC_BIT] = isDisplay;
        tag[DEST_W-1:0] = dest;
        return tag;
    endfunction

endpackage

// File: rtl/ddr_arb_pick.sv
// ddr_arb_pick: combinational priority decision between the display port and the
// ring queue. Display wins unless it has used up its run while the ring is eligible.
module ddr_arb_pick
    import ddr_req_arbiter_pkg::*;
#(
    parameter int unsigned MAX_DC_RUN = DEF_MAX_DC_RUN
) (
    input  logic       dcElig,
    input  logic       ringRdElig,
    input  logic       ringWrElig,
    input  logic [3:0] dcRun,
    output grant_t     grant
);

    localparam logic [3:0] MaxRun = 4'(MAX_DC_RUN);

    logic ringTurn;
    logic dcWins;

    assign ringTurn = (ringRdElig | ringWrElig) & (dcRun == MaxRun);
    assign dcWins   = dcElig & ~ringTurn;

    // Resolve eligibility flags into a one-hot grant
    always_comb begin
        grant = '0;
        if (dcWins) begin
            grant[GNT_DC] = 1'b1;
        end else if (ringRdElig) begin
            grant[GNT_RD] = 1'b1;
        end else if (ringWrElig) begin
            grant[GNT_WR] = 1'b1;
        end
    end

endmodule

// File: rtl/ddr_req_arbiter.sv
// ddr_req_arbiter: schedules the DDR2 command path between the ring memOp queue and
// the display refresh-read port, streams write beats, and pushes read-return tags.
// Optional statistics counters are enabled by defining DDR_ARB_STATS_EN.
module ddr_req_arbiter
    import ddr_req_arbiter_pkg::*;
#(
    parameter int unsigned WB_BEATS   = DEF_WB_BEATS,
    parameter int unsigned READ_BIT   = DEF_READ_BIT,
    parameter int unsigned MAX_DC_RUN = DEF_MAX_DC_RUN
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              memOpQempty,
    input  logic [DEST_W-1:0] memOpDest,
    input  logic [31:0]       memOpData,
    output logic              rdMemOp,
    input  logic              writeDataQempty,
    input  logic [127:0]      writeDataIn,
    output logic              rdWriteData,
    input  logic              readReq,
    input  logic [ADDR_W-1:0] RA,
    output logic              readAck,
    input  logic              afFull,
    input  logic              wbFull,
    output logic              wrAF,
    output logic [ADDR_W-1:0] afAddress,
    output logic              afRead,
    output logic              wrWB,
    output logic [127:0]      writeData,
    output logic              tagWr,
    output logic [TAG_W-1:0]  tagOut,
    input  logic              tagFull
`ifdef DDR_ARB_STATS_EN
    ,
    output logic [31:0]       statDcGrants,
    output logic [31:0]       statRingReads,
    output logic [31:0]       statRingWrites,
    output logic [31:0]       statStallCycles
`endif
);

    localparam logic [2:0] LastBeat = 3'(WB_BEATS - 1);
    localparam logic [3:0] MaxRun   = 4'(MAX_DC_RUN);

    arbState_e  state_q, state_d;
    logic [2:0] beatCnt_q, beatCnt_d;
    logic [3:0] dcRun_q, dcRun_d;

    logic   inIdle, isRead, beatOk;
    logic   dcElig, ringRdElig, ringWrElig;
    grant_t grant;
    logic   unusedBits;

    // Only the address field and the read flag of the op word are consumed
    assign unusedBits = ^memOpData;

    assign inIdle     = (state_q == StIdle);
    assign isRead     = memOpData[READ_BIT];
    assign beatOk     = ~writeDataQempty & ~wbFull;
    assign dcElig     = inIdle & readReq & ~afFull & ~tagFull;
    assign ringRdElig = inIdle & ~memOpQempty & isRead & ~afFull & ~tagFull;
    assign ringWrElig = inIdle & ~memOpQempty & ~isRead & ~afFull & ~wbFull & ~writeDataQempty;

    ddr_arb_pick #(
        .MAX_DC_RUN (MAX_DC_RUN)
    ) u_pick (
        .dcElig     (dcElig),
        .ringRdElig (ringRdElig),
        .ringWrElig (ringWrElig),
        .dcRun      (dcRun_q),
        .grant      (grant)
    );

    // State, beat counter and display-run counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            beatCnt_q <= '0;
            dcRun_q   <= '0;
        end else begin
            state_q   <= state_d;
            beatCnt_q <= beatCnt_d;
            dcRun_q   <= dcRun_d;
        end
    end

    // Display run length: counts display wins while the ring waits, saturates at the limit
    always_comb begin
        dcRun_d = dcRun_q;
        if (memOpQempty || grant[GNT_RD] || grant[GNT_WR]) begin
            dcRun_d = '0;
        end else if (grant[GNT_DC] && (dcRun_q != MaxRun)) begin
            dcRun_d = dcRun_q + 4'd1;
        end
    end

    // Next-state logic and output strobes/muxing; strobes are held low during reset
    always_comb begin
        state_d     = state_q;
        beatCnt_d   = beatCnt_q;
        readAck     = 1'b0;
        rdMemOp     = 1'b0;
        rdWriteData = 1'b0;
        wrAF        = 1'b0;
        afRead      = 1'b1;
        afAddress   = memOpData[ADDR_W-1:0];
        wrWB        = 1'b0;
        writeData   = writeDataIn;
        tagWr       = 1'b0;
        tagOut      = makeTag(1'b0, memOpDest);

        unique case (state_q)
            StIdle: begin
                if (grant[GNT_DC]) begin
                    readAck   = 1'b1;
                    wrAF      = 1'b1;
                    afAddress = RA;
                    tagWr     = 1'b1;
                    tagOut    = makeTag(1'b1, '0);
                end else if (grant[GNT_RD]) begin
                    rdMemOp = 1'b1;
                    wrAF    = 1'b1;
                    tagWr   = 1'b1;
                end else if (grant[GNT_WR]) begin
                    rdMemOp     = 1'b1;
                    wrAF        = 1'b1;
                    afRead      = 1'b0;
                    rdWriteData = 1'b1;
                    wrWB        = 1'b1;
                    if (WB_BEATS > 1) begin
                        state_d   = StWrData;
                        beatCnt_d = 3'd1;
                    end
                end
            end
            StWrData: begin
                if (beatOk) begin
                    rdWriteData = 1'b1;
                    wrWB        = 1'b1;
                    if (beatCnt_q == LastBeat) begin
                        state_d   = StIdle;
                        beatCnt_d = '0;
                    end else begin
                        beatCnt_d = beatCnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d   = StIdle;
                beatCnt_d = '0;
            end
        endcase

        if (reset) begin
            readAck     = 1'b0;
            rdMemOp     = 1'b0;
            rdWriteData = 1'b0;
            wrAF        = 1'b0;
            wrWB        = 1'b0;
            tagWr       = 1'b0;
        end
    end

`ifdef DDR_ARB_STATS_EN
    logic anyPending, anyGrant;

    assign anyPending = readReq | ~memOpQempty;
    assign anyGrant   = wrAF | wrWB;

    // Saturating grant and stall statistics
    always_ff @(posedge clock) begin
        if (reset) begin
            statDcGrants    <= '0;
            statRingReads   <= '0;
            statRingWrites  <= '0;
            statStallCycles <= '0;
        end else begin
            if (readAck && (statDcGrants != '1)) begin
                statDcGrants <= statDcGrants + 32'd1;
            end
            if (rdMemOp && afRead && (statRingReads != '1)) begin
                statRingReads <= statRingReads + 32'd1;
            end
            if (rdMemOp && !afRead && (statRingWrites != '1)) begin
                statRingWrites <= statRingWrites + 32'd1;
            end
            if (anyPending && !anyGrant && (statStallCycles != '1)) begin
                statStallCycles <= statStallCycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ddr_req_arbiter.sv
// tb_ddr_req_arbiter: directed scenarios plus randomized traffic checked against a
// cycle-level behavioural model of the arbitration rules.
module tb_ddr_req_arbiter;

    localparam int unsigned WB = 2;
    localparam int unsigned RB = 28;
    localparam int unsigned MR = 4;

    // Strobe vector layout: {readAck, rdMemOp, wrAF, tagWr, rdWriteData, wrWB}
    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] DC_G = 6'b101100;
    localparam logic [5:0] RD_G = 6'b011100;
    localparam logic [5:0] WR_G = 6'b011011;
    localparam logic [5:0] BEAT = 6'b000011;

    logic         clock = 1'b0;
    logic         reset;
    logic         memOpQempty;
    logic [3:0]   memOpDest;
    logic [31:0]  memOpData;
    logic         rdMemOp;
    logic         writeDataQempty;
    logic [127:0] writeDataIn;
    logic         rdWriteData;
    logic         readReq;
    logic [25:0]  RA;
    logic         readAck;
    logic         afFull;
    logic         wbFull;
    logic         wrAF;
    logic [25:0]  afAddress;
    logic         afRead;
    logic         wrWB;
    logic [127:0] writeData;
    logic         tagWr;
    logic [4:0]   tagOut;
    logic         tagFull;

    logic [5:0] obs;
    assign obs = {readAck, rdMemOp, wrAF, tagWr, rdWriteData, wrWB};

    int nChecks = 0;
    int nErrors = 0;

    // Model state: whether a write is streaming, beats already pushed, display run length
    bit mWriting;
    int mBeats;
    int mDcRun;

    typedef struct packed {
        logic [5:0]   strb;
        logic         afRd;
        logic [25:0]  addr;
        logic [4:0]   tag;
        logic [127:0] wd;
    } exp_t;

    always #5 clock = ~clock;

    ddr_req_arbiter #(
        .WB_BEATS   (WB),
        .READ_BIT   (RB),
        .MAX_DC_RUN (MR)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .memOpQempty     (memOpQempty),
        .memOpDest       (memOpDest),
        .memOpData       (memOpData),
        .rdMemOp         (rdMemOp),
        .writeDataQempty (writeDataQempty),
        .writeDataIn     (writeDataIn),
        .rdWriteData     (rdWriteData),
        .readReq         (readReq),
        .RA              (RA),
        .readAck         (readAck),
        .afFull          (afFull),
        .wbFull          (wbFull),
        .wrAF            (wrAF),
        .afAddress       (afAddress),
        .afRead          (afRead),
        .wrWB            (wrWB),
        .writeData       (writeData),
        .tagWr           (tagWr),
        .tagOut          (tagOut),
        .tagFull         (tagFull)
    );

    function automatic exp_t model_expect();
        exp_t e;
        bit   isRd, dcOk, ringOk;
        e = '0;
        if (reset) return e;
        if (!mWriting) begin
            isRd   = memOpData[RB];
            dcOk   = readReq && !afFull && !tagFull;
            ringOk = !memOpQempty && !afFull &&
                     (isRd ? !tagFull : (!wbFull && !writeDataQempty));
            if (dcOk && !(ringOk && mDcRun >= MR)) begin
                e.strb = DC_G; e.afRd = 1'b1; e.addr = RA; e.tag = 5'h10;
            end else if (ringOk && isRd) begin
                e.strb = RD_G; e.afRd = 1'b1; e.addr = memOpData[25:0];
                e.tag  = {1'b0, memOpDest};
            end else if (ringOk) begin
                e.strb = WR_G; e.afRd = 1'b0; e.addr = memOpData[25:0]; e.wd = writeDataIn;
            end
        end else if (!writeDataQempty && !wbFull) begin
            e.strb = BEAT; e.wd = writeDataIn;
        end
        return e;
    endfunction

    task automatic model_update(input exp_t e);
        if (reset) begin
            mWriting = 1'b0; mBeats = 0; mDcRun = 0;
        end else begin
            if (memOpQempty || e.strb[4]) mDcRun = 0;
            else if (e.strb[5]) mDcRun = (mDcRun < MR) ? mDcRun + 1 : MR;
            if (mWriting) begin
                if (e.strb[0]) begin
                    mBeats++;
                    if (mBeats == WB) begin
                        mWriting = 1'b0; mBeats = 0;
                    end
                end
            end else if (e.strb == WR_G && WB > 1) begin
                mWriting = 1'b1; mBeats = 1;
            end
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        readReq = 1'b0; RA = '0;
        memOpQempty = 1'b1; memOpDest = '0; memOpData = '0;
        writeDataQempty = 1'b1; writeDataIn = '0;
        afFull = 1'b0; wbFull = 1'b0; tagFull = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1; readReq = 1'b1; memOpQempty = 1'b0; memOpData = 32'h1000_0000;
        #1;
        nChecks++;
        if (obs !== NONE) begin
            nErrors++; $display("FAIL reset_strobes: got %b want %b", obs, NONE);
        end
        next_cycle();
        #1;
        nChecks++;
        if (obs !== NONE) begin
            nErrors++; $display("FAIL reset_strobes_held: got %b want %b", obs, NONE);
        end
        reset = 1'b0;
        #1;
        nChecks++;
        if (obs !== DC_G) begin
            nErrors++; $display("FAIL post_reset_idle: got %b want %b", obs, DC_G);
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_display_only();
        apply_reset();
        readReq = 1'b1; RA = 26'h0001230;
        for (int i = 0; i < 5; i++) begin
            #1;
            nChecks++;
            if (obs !== DC_G) begin
                nErrors++; $display("FAIL dc_only_strobes[%0d]: got %b want %b", i, obs, DC_G);
            end
            nChecks++;
            if ({afRead, afAddress, tagOut} !== {1'b1, 26'h0001230, 5'h10}) begin
                nErrors++;
                $display("FAIL dc_only_data[%0d]: got rd=%b addr=%h tag=%h want rd=1 addr=0001230 tag=10",
                         i, afRead, afAddress, tagOut);
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_ring_read();
        apply_reset();
        memOpQempty = 1'b0; memOpDest = 4'd3; memOpData = 32'h1000_0000 | 32'h00AB_CDEF;
        #1;
        nChecks++;
        if (obs !== RD_G) begin
            nErrors++; $display("FAIL ring_read_strobes: got %b want %b", obs, RD_G);
        end
        nChecks++;
        if ({afRead, afAddress, tagOut} !== {1'b1, 26'h0ABCDEF, 5'h03}) begin
            nErrors++;
            $display("FAIL ring_read_data: got rd=%b addr=%h tag=%h want rd=1 addr=0abcdef tag=03",
                     afRead, afAddress, tagOut);
        end
        next_cycle();
        memOpQempty = 1'b1;
        #1;
        nChecks++;
        if (obs !== NONE) begin
            nErrors++; $display("FAIL ring_read_single: got %b want %b", obs, NONE);
        end
        idle_inputs();
    endtask

    task automatic test_ring_write_stall();
        logic [127:0] beatA, beatB;
        beatA = {4{32'hA5A5_0001}};
        beatB = {4{32'h5B5B_0002}};
        apply_reset();
        memOpQempty = 1'b0; memOpData = 32'h0012_3456; writeDataQempty = 1'b0;
        writeDataIn = beatA;
        #1;
        nChecks++;
        if (obs !== WR_G || afRead !== 1'b0 || afAddress !== 26'h0123456 || writeData !== beatA) begin
            nErrors++;
            $display("FAIL write_t0: got strb=%b rd=%b addr=%h wd=%h want strb=%b rd=0 addr=0123456 wd=%h",
                     obs, afRead, afAddress, writeData, WR_G, beatA);
        end
        next_cycle();
        memOpQempty = 1'b1; writeDataIn = beatB; wbFull = 1'b1; readReq = 1'b1; RA = 26'h55;
        for (int i = 1; i <= 3; i++) begin
            #1;
            nChecks++;
            if (obs !== NONE) begin
                nErrors++; $display("FAIL write_stall_t%0d: got %b want %b", i, obs, NONE);
            end
            next_cycle();
        end
        wbFull = 1'b0;
        #1;
        nChecks++;
        if (obs !== BEAT || writeData !== beatB) begin
            nErrors++;
            $display("FAIL write_t4: got strb=%b wd=%h want strb=%b wd=%h", obs, writeData, BEAT, beatB);
        end
        next_cycle();
        writeDataQempty = 1'b1;
        #1;
        nChecks++;
        if (obs !== DC_G) begin
            nErrors++; $display("FAIL write_then_dc: got %b want %b", obs, DC_G);
        end
        idle_inputs();
    endtask

    task automatic test_dc_fairness();
        logic [5:0] want;
        apply_reset();
        readReq = 1'b1; RA = 26'h7;
        memOpQempty = 1'b0; memOpDest = 4'd5; memOpData = 32'h1000_0100;
        for (int i = 0; i < 10; i++) begin
            want = (i % 5 == 4) ? RD_G : DC_G;
            #1;
            nChecks++;
            if (obs !== want) begin
                nErrors++; $display("FAIL dc_fair[%0d]: got %b want %b", i, obs, want);
            end
            // A popped op is replaced by the next queued read
            if (want == RD_G) memOpData = memOpData + 32'h40;
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_af_full();
        apply_reset();
        readReq = 1'b1; memOpQempty = 1'b0; memOpData = 32'h1000_0200; afFull = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            nChecks++;
            if (obs !== NONE) begin
                nErrors++; $display("FAIL af_full[%0d]: got %b want %b", i, obs, NONE);
            end
            next_cycle();
        end
        afFull = 1'b0;
        #1;
        nChecks++;
        if (obs !== DC_G) begin
            nErrors++; $display("FAIL af_resume_dc: got %b want %b", obs, DC_G);
        end
        next_cycle();
        readReq = 1'b0;
        #1;
        nChecks++;
        if (obs !== RD_G) begin
            nErrors++; $display("FAIL af_resume_ring: got %b want %b", obs, RD_G);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_write();
        apply_reset();
        memOpQempty = 1'b0; memOpData = 32'h0000_0800; writeDataQempty = 1'b0;
        writeDataIn = {4{32'hC0C0_0003}};
        #1;
        nChecks++;
        if (obs !== WR_G) begin
            nErrors++; $display("FAIL rst_mid_t0: got %b want %b", obs, WR_G);
        end
        next_cycle();
        reset = 1'b1; memOpQempty = 1'b1;
        #1;
        nChecks++;
        if (obs !== NONE) begin
            nErrors++; $display("FAIL rst_mid_in_reset: got %b want %b", obs, NONE);
        end
        next_cycle();
        reset = 1'b0;
        #1;
        nChecks++;
        if (obs !== NONE) begin
            nErrors++; $display("FAIL rst_mid_idle: got %b want %b", obs, NONE);
        end
        next_cycle();
        memOpQempty = 1'b0; memOpData = 32'h0000_0900; writeDataIn = {4{32'hC1C1_0004}};
        #1;
        nChecks++;
        if (obs !== WR_G || afAddress !== 26'h0000900) begin
            nErrors++;
            $display("FAIL rst_fresh_t0: got strb=%b addr=%h want strb=%b addr=0000900",
                     obs, afAddress, WR_G);
        end
        next_cycle();
        memOpQempty = 1'b1; writeDataIn = {4{32'hD1D1_0005}};
        #1;
        nChecks++;
        if (obs !== BEAT || writeData !== {4{32'hD1D1_0005}}) begin
            nErrors++;
            $display("FAIL rst_fresh_t1: got strb=%b wd=%h want strb=%b", obs, writeData, BEAT);
        end
        next_cycle();
        writeDataQempty = 1'b1; readReq = 1'b1;
        #1;
        nChecks++;
        if (obs !== DC_G) begin
            nErrors++; $display("FAIL rst_fresh_done: got %b want %b", obs, DC_G);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        exp_t e;
        apply_reset();
        mWriting = 1'b0; mBeats = 0; mDcRun = 0;
        for (int i = 0; i < 600; i++) begin
            reset           = ($urandom_range(0, 63) == 0);
            readReq         = ($urandom_range(0, 2) != 0);
            RA              = 26'($urandom);
            memOpQempty     = ($urandom_range(0, 3) == 0);
            memOpDest       = 4'($urandom);
            memOpData       = $urandom;
            writeDataQempty = ($urandom_range(0, 4) == 0);
            writeDataIn     = {$urandom, $urandom, $urandom, $urandom};
            afFull          = ($urandom_range(0, 5) == 0);
            wbFull          = ($urandom_range(0, 4) == 0);
            tagFull         = ($urandom_range(0, 5) == 0);
            #1;
            e = model_expect();
            nChecks++;
            if (obs !== e.strb) begin
                nErrors++; $display("FAIL rand_strobes[%0d]: got %b want %b", i, obs, e.strb);
            end
            if (e.strb[3]) begin
                nChecks++;
                if ({afRead, afAddress} !== {e.afRd, e.addr}) begin
                    nErrors++;
                    $display("FAIL rand_af[%0d]: got rd=%b addr=%h want rd=%b addr=%h",
                             i, afRead, afAddress, e.afRd, e.addr);
                end
            end
            if (e.strb[2]) begin
                nChecks++;
                if (tagOut !== e.tag) begin
                    nErrors++; $display("FAIL rand_tag[%0d]: got %h want %h", i, tagOut, e.tag);
                end
            end
            if (e.strb[0]) begin
                nChecks++;
                if (writeData !== e.wd) begin
                    nErrors++; $display("FAIL rand_wd[%0d]: got %h want %h", i, writeData, e.wd);
                end
            end
            model_update(e);
            next_cycle();
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        @(negedge clock);
        test_reset();
        test_display_only();
        test_ring_read();
        test_ring_write_stall();
        test_dc_fairness();
        test_af_full();
        test_reset_mid_write();
        test_random();
        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
